led_array_ctrl: RTL and testbench
=================================

// Module: led_array_ctrl
// PURPOSE
//  Parametrised multi-channel LED driver; successor to the single free-running LED count divider.
//  Per-channel mode register (OFF/ON/BLINK/PWM) written through a one-cycle config strobe.
//  Shared blink-tick prescaler and shared PWM ramp; outputs registered, optional active-low polarity.
//  Sits at board top level between the system clock buffer and the LED pins.
// PARAMETERS
//  NCH        4           number of LED channels (1..32)
//  TICK_DIV   50_000_000  clk cycles per blink tick (>=2)
//  PWM_W      8           PWM counter/duty width in bits (2..16)
//  ACTIVE_LOW 1           1: led_out driven inverted (pin low = lit)
// PORTS
//  clk       in   1                 system clock
//  reset     in   1                 async, active-high reset
//  cfg_wr    in   1                 config write strobe, sampled on posedge clk
//  cfg_ch    in   $clog2(NCH)>0?:1  target channel index
//  cfg_mode  in   2                 0 OFF, 1 ON, 2 BLINK, 3 PWM
//  cfg_duty  in   PWM_W             PWM duty (used in mode 3; stored in all modes)
//  cfg_ack   out  1                 1-cycle pulse: write accepted
//  cfg_err   out  1                 1-cycle pulse: write rejected (cfg_ch >= NCH)
//  tick      out  1                 1-cycle pulse at each blink tick
//  led_out   out  NCH               LED pin drive, after polarity
// BEHAVIOUR
//  Reset (async assert, sync release): modes=OFF, duty=0, blink phase=0, div_cnt=0, pwm_cnt=0,
//   tick=0, cfg_ack=0, cfg_err=0, led_out = ACTIVE_LOW ? '1 : '0 (all dark). Reset mid-operation
//   returns everything to these values immediately; no write in flight survives.
//  Prescaler: div_cnt counts 0..TICK_DIV-1 then wraps to 0; internal tick_i=1 when div_cnt==TICK_DIV-1.
//   Output tick is tick_i registered (1-cycle delay). First tick_i at cycle TICK_DIV-1 after reset release.
//  PWM ramp: pwm_cnt PWM_W bits, +1 every cycle, wraps 2^PWM_W-1 -> 0 (period 2^PWM_W).
//  Blink phase[ch]: toggles on tick_i when mode[ch]==BLINK; forced 0 when mode[ch]!=BLINK.
//  Lit function lit[ch]: OFF->0; ON->1; BLINK->phase[ch]; PWM->(pwm_cnt < duty[ch]) unsigned.
//   duty=0 never lit; duty=2^PWM_W-1 lit 2^PWM_W-1 of 2^PWM_W cycles (never 100%; use ON).
//  led_out[ch] <= lit[ch] ^ ACTIVE_LOW, registered: 1-cycle latency from internal state.
//  Config write: on edge with cfg_wr=1 and cfg_ch<NCH: mode[cfg_ch]<=cfg_mode, duty[cfg_ch]<=cfg_duty,
//   phase[cfg_ch]<=0; cfg_ack=1 next cycle. Effect visible on led_out one edge after the write edge.
//   cfg_ch>=NCH (non-power-of-2 NCH): no state change, cfg_err=1 next cycle, cfg_ack=0.
//  Back-to-back writes every cycle accepted; each gets its own ack pulse. No backpressure.
//  Write and tick_i on same channel same edge: write wins (phase=0). Other channels toggle normally.
//  Rewriting BLINK to a blinking channel restarts it dark; first lit half begins at next tick.
//  Writes never disturb div_cnt or pwm_cnt (channels stay phase-coherent).
// TESTING (bench: NCH=4, TICK_DIV=10, PWM_W=4, ACTIVE_LOW=1)
//  Reset held then released, no writes -> led_out=4'hF for 100 cycles; tick pulses at cycles 10,20,30.. (1 wide).
//  Write ch1 ON -> cfg_ack pulse next cycle; led_out=4'hD from cycle after write; others unchanged.
//  Write ch2 BLINK -> ch2 dark until next tick_i, then alternates lit/dark every 10 cycles (20-cycle period).
//  Write ch0 PWM duty=4 -> led_out[0] low exactly 4 of every 16 cycles, aligned to pwm_cnt 0..3;
//   duty=0 -> always high; duty=15 -> high 1 of 16.
//  Write to ch2 BLINK coincident with tick_i -> phase stays 0; cfg_ch=5 with NCH=5 build -> cfg_err pulse, state unchanged.
//  Assert reset while ch1 ON and ch2 blinking -> led_out=4'hF asynchronously; after release all OFF, counters from 0.

Source files
------------

// File: rtl/led_array_ctrl.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM mode, shared blink prescaler
// and PWM ramp, registered outputs with optional active-low polarity.
module led_array_ctrl #(
    parameter int NCH        = 4,
    parameter int TICK_DIV   = 50_000_000,
    parameter int PWM_W      = 8,
    parameter int ACTIVE_LOW = 1,
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [PWM_W-1:0] cfg_duty,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             tick,
    output logic [NCH-1:0]   led_out
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    localparam int               DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CH_W:0]    NCH_L    = (CH_W + 1)'(NCH);
    localparam logic [NCH-1:0]   POL      = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIV_W-1:0] r_div_cnt;
    logic [PWM_W-1:0] r_pwm_cnt;
    mode_t            r_mode [NCH];
    logic [PWM_W-1:0] r_duty [NCH];
    logic [NCH-1:0]   r_phase;
    logic             r_tick;
    logic             r_ack;
    logic             r_err;
    logic [NCH-1:0]   r_led;

    logic             w_tick_i;
    logic             w_ch_ok;
    logic [NCH-1:0]   w_wr_hit;
    logic [NCH-1:0]   w_lit;

    assign w_tick_i = (r_div_cnt == DIV_LAST);
    // Extra MSB lets the range check reject indices of a non-power-of-2 channel count.
    assign w_ch_ok  = ({1'b0, cfg_ch} < NCH_L);

    always_comb begin
        w_wr_hit = '0;
        w_lit    = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            w_wr_hit[i] = cfg_wr && w_ch_ok && (cfg_ch == CH_W'(i));
            case (r_mode[i])
                MODE_OFF:   w_lit[i] = 1'b0;
                MODE_ON:    w_lit[i] = 1'b1;
                MODE_BLINK: w_lit[i] = r_phase[i];
                MODE_PWM:   w_lit[i] = (r_pwm_cnt < r_duty[i]);
                default:    w_lit[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_pwm_cnt <= '0;
            r_tick    <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_led     <= POL;
        end else begin
            r_div_cnt <= w_tick_i ? '0 : r_div_cnt + DIV_W'(1);
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            r_tick    <= w_tick_i;
            r_ack     <= cfg_wr && w_ch_ok;
            r_err     <= cfg_wr && !w_ch_ok;
            r_led     <= w_lit ^ POL;
        end
    end

    // A write to a channel overrides a coincident tick, restarting its blink dark.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                r_mode[i] <= MODE_OFF;
                r_duty[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (w_wr_hit[i]) begin
                    r_mode[i]  <= mode_t'(cfg_mode);
                    r_duty[i]  <= cfg_duty;
                    r_phase[i] <= 1'b0;
                end else if (r_mode[i] != MODE_BLINK) begin
                    r_phase[i] <= 1'b0;
                end else if (w_tick_i) begin
                    r_phase[i] <= ~r_phase[i];
                end
            end
        end
    end

    assign cfg_ack = r_ack;
    assign cfg_err = r_err;
    assign tick    = r_tick;
    assign led_out = r_led;

endmodule

// File: tb/tb_led_array_ctrl.sv
// Bench for led_array_ctrl: directed + random config writes against an arithmetic model
// built on the edge count since reset release.
module tb_led_array_ctrl;

    localparam int NCH      = 4;
    localparam int TICK_DIV = 10;
    localparam int PWM_W    = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;

    logic       cfg_wr   = 1'b0;
    logic [1:0] cfg_ch   = '0;
    logic [1:0] cfg_mode = '0;
    logic [3:0] cfg_duty = '0;
    logic       cfg_ack, cfg_err, tick;
    logic [3:0] led_out;

    logic       cfg5_wr   = 1'b0;
    logic [2:0] cfg5_ch   = '0;
    logic [1:0] cfg5_mode = '0;
    logic [3:0] cfg5_duty = '0;
    logic       ack5, err5, tick5;
    logic [4:0] led5;

    always #5 clk = ~clk;

    led_array_ctrl #(.NCH(NCH), .TICK_DIV(TICK_DIV), .PWM_W(PWM_W), .ACTIVE_LOW(1)) u_dut (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_duty(cfg_duty), .cfg_ack(cfg_ack), .cfg_err(cfg_err), .tick(tick), .led_out(led_out)
    );

    led_array_ctrl #(.NCH(5), .TICK_DIV(TICK_DIV), .PWM_W(PWM_W), .ACTIVE_LOW(1)) u_dut5 (
        .clk(clk), .reset(reset), .cfg_wr(cfg5_wr), .cfg_ch(cfg5_ch), .cfg_mode(cfg5_mode),
        .cfg_duty(cfg5_duty), .cfg_ack(ack5), .cfg_err(err5), .tick(tick5), .led_out(led5)
    );

    int tests = 0;
    int fails = 0;

    // Model: edges since release, plus per-channel mode/duty and the edge of the last write.
    int edge_n;
    int m_mode  [NCH];
    int m_duty  [NCH];
    int m_wedge [NCH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_lit(input int ch, input int k);
        case (m_mode[ch])
            1:       return 1'b1;
            2:       return (((k / TICK_DIV) - (m_wedge[ch] / TICK_DIV)) % 2) == 1;
            3:       return (k % (1 << PWM_W)) < m_duty[ch];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] model_led(input int k);
        logic [3:0] v;
        for (int ch = 0; ch < NCH; ch++) v[ch] = ~model_lit(ch, k);
        return v;
    endfunction

    task automatic model_reset();
        edge_n = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            m_mode[ch]  = 0;
            m_duty[ch]  = 0;
            m_wedge[ch] = 0;
        end
    endtask

    // One clock: drive inputs, take the edge, check outputs, then commit the write to the model.
    task automatic step(input logic wr, input int ch, input int mode, input int duty);
        cfg_wr   = wr;
        cfg_ch   = 2'(ch);
        cfg_mode = 2'(mode);
        cfg_duty = 4'(duty);
        @(posedge clk);
        edge_n++;
        #1;
        check("led_out", 32'(led_out), 32'(model_led(edge_n - 1)));
        check("tick", 32'(tick), 32'((edge_n % TICK_DIV) == 0));
        check("cfg_ack", 32'(cfg_ack), 32'(wr));
        check("cfg_err", 32'(cfg_err), 32'(0));
        if (wr) begin
            m_mode[ch]  = mode;
            m_duty[ch]  = duty;
            m_wedge[ch] = edge_n;
        end
        cfg_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_led", 32'(led_out), 32'hF);
        check("reset_tick", 32'(tick), 32'(0));
        check("reset_ack", 32'(cfg_ack), 32'(0));
        check("reset_led5", 32'(led5), 32'h1F);
        @(negedge clk);
        reset = 1'b0;

        // Out-of-range channel on the 5-channel build, then a valid write to ch4.
        cfg5_wr = 1'b1; cfg5_ch = 3'd5;
        step(1'b0, 0, 0, 0);
        check("err5_ch5", 32'(err5), 32'(1));
        check("ack5_ch5", 32'(ack5), 32'(0));
        cfg5_ch = 3'd7;
        step(1'b0, 0, 0, 0);
        check("err5_ch7", 32'(err5), 32'(1));
        check("led5_unch", 32'(led5), 32'h1F);
        cfg5_ch = 3'd4; cfg5_mode = 2'd1;
        step(1'b0, 0, 0, 0);
        check("ack5_ch4", 32'(ack5), 32'(1));
        check("err5_ch4", 32'(err5), 32'(0));
        cfg5_wr = 1'b0;
        step(1'b0, 0, 0, 0);
        check("led5_ch4on", 32'(led5), 32'h0F);
        check("ack5_idle", 32'(ack5), 32'(0));

        idle(96);
        step(1'b1, 1, 1, 0);
        idle(3);
        step(1'b1, 2, 2, 0);
        idle(45);
        step(1'b1, 0, 3, 4);
        idle(40);
        step(1'b1, 0, 3, 0);
        idle(20);
        step(1'b1, 0, 3, 15);
        idle(36);

        // Rewrite ch2 BLINK on the edge where the prescaler ticks, then mid-phase.
        while (((edge_n + 1) % TICK_DIV) != 0) step(1'b0, 0, 0, 0);
        step(1'b1, 2, 2, 0);
        idle(27);
        step(1'b1, 2, 2, 0);
        idle(30);

        for (int i = 0; i < 500; i++) begin
            int d;
            case ($urandom_range(0, 3))
                0:       d = 0;
                1:       d = 15;
                default: d = int'($urandom_range(0, 15));
            endcase
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d);
        end

        step(1'b1, 1, 1, 0);
        step(1'b1, 2, 2, 0);
        idle(17);
        #2;
        reset = 1'b1;
        #1;
        check("async_led", 32'(led_out), 32'hF);
        check("async_tick", 32'(tick), 32'(0));
        check("async_led5", 32'(led5), 32'h1F);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle(25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
